// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_unit
// Brief  : ALUCtl executor with 1-cycle ALU ops, serial shifter and valid/ready handshakes.
// Rev    : 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_XOR  = 4'b0011;
  localparam logic [3:0] c_ALU_SLL  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SRA  = 4'b0111;
  localparam logic [3:0] c_ALU_SLT  = 4'b1000;
  localparam logic [3:0] c_ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_result;
  logic                 r_zero;
  logic                 r_illegal;
  logic [XLEN-1:0]      r_work;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_sh_kind;

  logic                 w_is_shift;
  logic                 w_defined;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [XLEN-1:0]      w_alu_res;
  logic [XLEN-1:0]      w_done_res;
  logic [XLEN-1:0]      w_sh_next;

  assign w_is_shift = (alu_ctl == c_ALU_SLL) || (alu_ctl == c_ALU_SRL) ||
                      (alu_ctl == c_ALU_SRA);
  assign w_defined  = (alu_ctl <= c_ALU_SLTU);
  assign w_shamt    = op_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    case (alu_ctl)
      c_ALU_AND:  w_alu_res = op_a & op_b;
      c_ALU_OR:   w_alu_res = op_a | op_b;
      c_ALU_ADD:  w_alu_res = op_a + op_b;
      c_ALU_XOR:  w_alu_res = op_a ^ op_b;
      c_ALU_SUB:  w_alu_res = op_a - op_b;
      c_ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:    w_alu_res = '0;
    endcase
  end

  // A shift with zero amount completes immediately and passes op_a through.
  assign w_done_res = w_is_shift ? op_a : w_alu_res;

  // r_sh_kind holds alu_ctl[1:0]: 00 SLL, 01 SRL, 11 SRA.
  always_comb begin
    w_sh_next = r_work;
    case (r_sh_kind)
      2'b00:   w_sh_next = {r_work[XLEN-2:0], 1'b0};
      2'b01:   w_sh_next = {1'b0, r_work[XLEN-1:1]};
      default: w_sh_next = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_sh_kind   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_is_shift && (w_shamt != '0)) begin
              r_work    <= op_a;
              r_cnt     <= w_shamt;
              r_sh_kind <= alu_ctl[1:0];
              r_state   <= S_SHIFT;
            end else begin
              r_result    <= w_done_res;
              r_zero      <= (w_done_res == '0);
              r_illegal   <= ~w_defined;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_sh_next;
          r_cnt  <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_sh_next;
            r_zero      <= (w_sh_next == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_exec_unit
// Brief  : Scoreboard bench for alu_exec_unit; expectations come from a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctl = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [4:0] sh;
    sh    = b[4:0];
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 1;
    case (ctl)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h3: e.res = a ^ b;
      4'h4: begin e.res = a << sh; e.lat = int'(sh) + 1; end
      4'h5: begin e.res = a >> sh; e.lat = int'(sh) + 1; end
      4'h6: e.res = a - b;
      4'h7: begin e.res = $signed(a) >>> sh; e.lat = int'(sh) + 1; end
      4'h8: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'h9: e.res = (a < b) ? 32'h1 : 32'h0;
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Push expectation, present the request for one accepting edge, then scramble inputs.
  task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(ctl, a, b));
    in_valid = 1'b1;
    alu_ctl  = ctl;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctl  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({out_valid, result, zero, illegal} !== 35'h0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%b r=%h z=%b i=%b want all 0", out_valid, result, zero, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    e = model(4'h0, 0, 0);
  endtask

  task automatic run_table(input string name, input logic [3:0] ctl[], input logic [31:0] a[], input logic [31:0] b[]);
    int lat;
    exp_t e;
    for (int i = 0; i < ctl.size(); i++) begin
      issue(ctl[i], a[i], b[i]);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, e.lat);
      end
      n_checks++;
      if ({result, zero, illegal} !== {e.res, e.z, e.ill}) begin
        n_errors++;
        $display("FAIL %s[%0d] ctl=%h got r=%h z=%b i=%b want r=%h z=%b i=%b",
                 name, i, ctl[i], result, zero, illegal, e.res, e.z, e.ill);
      end
      release_out();
    end
  endtask

  task automatic test_arith();
    logic [3:0]  c[] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'h6};
    logic [31:0] a[] = '{32'h7FFF_FFFF, 32'h5, 32'hF0F0_1234, 32'h0F00_0000, 32'hAAAA_5555, 32'h0};
    logic [31:0] b[] = '{32'h1, 32'h5, 32'h0FF0_FF00, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h1};
    run_table("arith", c, a, b);
  endtask

  task automatic test_compare();
    logic [3:0]  c[] = '{4'h8, 4'h9, 4'h8, 4'h9};
    logic [31:0] a[] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1};
    logic [31:0] b[] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_table("compare", c, a, b);
  endtask

  task automatic test_shift();
    logic [3:0]  c[] = '{4'h7, 4'h5, 4'h4, 4'h4, 4'h7, 4'h5, 4'h4};
    logic [31:0] a[] = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678,
                         32'h7F00_00F0, 32'hF000_000F, 32'h8000_0001};
    logic [31:0] b[] = '{32'd31, 32'd31, 32'h0000_0020, 32'd5, 32'd4, 32'hFFFF_FFE3, 32'd1};
    run_table("shift", c, a, b);
  endtask

  task automatic test_illegal();
    logic [3:0]  c[] = '{4'hC, 4'h2, 4'hA, 4'hF, 4'h9};
    logic [31:0] a[] = '{32'h1234, 32'h3, 32'hFFFF_FFFF, 32'h5, 32'h2};
    logic [31:0] b[] = '{32'h5678, 32'h4, 32'hFFFF_FFFF, 32'h5, 32'h3};
    run_table("illegal", c, a, b);
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e1;
    exp_t e2;
    issue(4'h2, 32'h0000_1000, 32'h0000_0234);
    wait_out(lat);
    e1 = sb.pop_front();
    sb.push_back(model(4'h6, 32'h10, 32'h20));
    in_valid = 1'b1;
    alu_ctl  = 4'h6;
    op_a     = 32'h10;
    op_b     = 32'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e1.res || zero !== e1.z) begin
        n_errors++;
        $display("FAIL backpressure[%0d] got v=%b rdy=%b r=%h z=%b want v=1 rdy=0 r=%h z=%b",
                 i, out_valid, in_ready, result, zero, e1.res, e1.z);
      end
    end
    release_out();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    wait_out(lat);
    e2 = sb.pop_front();
    n_checks++;
    if (lat != 1 || result !== e2.res || zero !== e2.z || illegal !== e2.ill) begin
      n_errors++;
      $display("FAIL bp_pending got lat=%0d r=%h z=%b i=%b want lat=1 r=%h z=%b i=%b",
               lat, result, zero, illegal, e2.res, e2.z, e2.ill);
    end
    release_out();
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0]  c[] = '{4'h2};
    logic [31:0] a[] = '{32'hFFFF_FFFF};
    logic [31:0] b[] = '{32'h0000_0002};
    issue(4'h4, 32'h0000_0001, 32'd20);
    repeat (6) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midshift_busy got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      n_errors++;
      $display("FAIL midshift_reset got out_valid=%b result=%h want 0 0", out_valid, result);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL midshift_after got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
    end
    run_table("post_reset", c, a, b);
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = a;
      issue(c, a, b);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat != e.lat || result !== e.res || zero !== e.z || illegal !== e.ill) begin
        n_errors++;
        $display("FAIL b2b[%0d] ctl=%h a=%h b=%h got lat=%0d r=%h z=%b i=%b want lat=%0d r=%h z=%b i=%b",
                 i, c, a, b, lat, result, zero, illegal, e.lat, e.res, e.z, e.ill);
      end
      release_out();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_hs[%0d] got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
